uart_tx_serializer: RTL and testbench

- Byte-wide UART transmitter that takes the byte presented by the UART data register and shifts it onto the serial line.
- Sits directly downstream of the transmit controller.
- The controller enables it with `en`, launches a frame with a one-cycle `tx_start` pulse, and waits for the one-cycle `done` pulse before checking whether the parallel-to-serial buffer is empty.
- Frame format: 1 start bit, 8 data bits LSB first, optional even parity bit, 1 or 2 stop bits.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_serializer_baud.sv | 41 ++++
 rtl/uart_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit serializer: state
//               encoding, default bit period and frame-length helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Serializer state encoding (3-bit)
    typedef logic [2:0] state_t;
    localparam state_t IDLE   = 3'd0;
    localparam state_t START  = 3'd1;
    localparam state_t DATA   = 3'd2;
    localparam state_t PARITY = 3'd3;
    localparam state_t STOP   = 3'd4;

    // 50 MHz clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Cycles from the accepting edge until done is high:
    // one bit period per start/data/parity/stop bit, plus the done cycle.
    function automatic int frame_cycles(input int cpb, input int parity_en,
                                        input int stop_bits);
        return cpb * (1 + 8 + parity_en + stop_bits) + 1;
    endfunction

    localparam int DEFAULT_FRAME_CYCLES = frame_cycles(DEFAULT_CLKS_PER_BIT, 0, 1);

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_baud.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises tick
//               on the last cycle of every bit period; clear restarts it.
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == C_LAST);
    // A cleared counter is never at a bit boundary, so tick is masked too
    assign tick   = w_last && !clear;

    // Free-running bit-period count, wrapping at each bit boundary
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Byte-wide UART transmitter. 1 start bit, 8 data bits LSB
//               first, optional even parity, 1 or 2 stop bits. All outputs
//               registered; done pulses for one cycle at end of frame.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] C_LAST_STOP = 3'(STOP_BITS - 1);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;
    logic       w_tick;
    logic       w_clear;

    // Hold the bit timer at zero whenever no frame is running or the frame
    // is being aborted, so every accepted frame starts a fresh bit period.
    assign w_clear = (r_state == IDLE) || !en;

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && !en) begin
                // Abort: drop the frame silently, no done pulse
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_tx      <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                        if (en && tx_start) begin
                            r_shift   <= data_in;
                            r_parity  <= ^data_in;
                            r_bit_cnt <= '0;
                            r_state   <= START;
                            r_tx      <= 1'b0;
                            r_busy    <= 1'b1;
                        end
                    end
                    START: begin
                        if (w_tick) begin
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                        end
                    end
                    DATA: begin
                        if (w_tick) begin
                            r_shift <= r_shift >> 1;
                            if (r_bit_cnt == 3'd7) begin
                                r_bit_cnt <= '0;
                                if (PARITY_EN != 0) begin
                                    r_state <= PARITY;
                                    r_tx    <= r_parity;
                                end else begin
                                    r_state <= STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_tx      <= r_shift[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (w_tick) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (w_tick) begin
                            // Bit counter is reused to count stop bits
                            if (r_bit_cnt == C_LAST_STOP) begin
                                r_state   <= IDLE;
                                r_bit_cnt <= '0;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer. Three instances
//               (no parity/1 stop, even parity/1 stop, no parity/2 stop)
//               share stimulus; sel picks the instance under observation.
//               Expected line bits are queued when a frame is launched.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       tx_start;
    logic [7:0] data_in;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    logic       tx_m, busy_m, done_m;
    int         sel;

    int nvec = 0;
    int nerr = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .en(en), .tx_start(tx_start), .data_in(data_in),
        .tx(tx0), .busy(busy0), .done(done0));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .tx_start(tx_start), .data_in(data_in),
        .tx(tx1), .busy(busy1), .done(done1));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .tx_start(tx_start), .data_in(data_in),
        .tx(tx2), .busy(busy2), .done(done2));

    // Observed instance
    always_comb begin
        tx_m   = tx0;
        busy_m = busy0;
        done_m = done0;
        if (sel == 1) begin
            tx_m = tx1; busy_m = busy1; done_m = done1;
        end else if (sel == 2) begin
            tx_m = tx2; busy_m = busy2; done_m = done2;
        end
    end

    // Advance one clock; outputs are then settled for the edge just taken
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        nvec++;
        if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            nerr++;
            $display("FAIL %s: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     name, tx_m, busy_m, done_m);
        end
    endtask

    // Reference frame: start, 8 data LSB first, optional even parity, stops
    task automatic push_frame(input logic [7:0] d, input int p, input int s);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (p != 0) exp_q.push_back(^d);
        for (int i = 0; i < s; i++) exp_q.push_back(1'b1);
    endtask

    // Launch a frame: the edge taken here is the accepting edge
    task automatic accept(input logic [7:0] d, input int p, input int s);
        en       = 1'b1;
        tx_start = 1'b1;
        data_in  = d;
        push_frame(d, p, s);
        step();
        tx_start = 1'b0;
        data_in  = ~d;
    endtask

    // Put every instance back in IDLE by dropping enable briefly
    task automatic quiesce();
        en       = 1'b0;
        tx_start = 1'b0;
        step();
        step();
        exp_q.delete();
    endtask

    // Compare one frame cycle by cycle against the queued bits.
    // mid_cycle: pulse tx_start with mid_data; abort_cycle: drop en;
    // rst_cycle: assert reset. Cycle 1 is the cycle after the accepting edge.
    task automatic check_frame(input int p, input int s, input int mid_cycle,
                               input logic [7:0] mid_data, input int abort_cycle,
                               input int rst_cycle, input string name);
        int   n_bits;
        int   c;
        logic exp_bit;
        n_bits = 9 + p + s;
        for (int b = 0; b < n_bits; b++) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL %s: expected-bit queue empty at bit %0d", name, b);
                return;
            end
            exp_bit = exp_q.pop_front();
            for (int k = 0; k < CPB; k++) begin
                c = b * CPB + k + 1;
                nvec++;
                if (tx_m !== exp_bit || busy_m !== 1'b1 || done_m !== 1'b0) begin
                    nerr++;
                    $display("FAIL %s cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                             name, c, tx_m, busy_m, done_m, exp_bit);
                end
                if (c == abort_cycle || c == rst_cycle) begin
                    if (c == abort_cycle) en = 1'b0;
                    else reset = 1'b1;
                    step();
                    reset = 1'b0;
                    check_idle({name, "_after_stop"});
                    for (int j = 0; j < 2 * CPB * s + CPB; j++) begin
                        step();
                        check_idle({name, "_no_done"});
                    end
                    exp_q.delete();
                    return;
                end
                tx_start = (c == mid_cycle);
                if (c == mid_cycle) data_in = mid_data;
                step();
            end
        end
        tx_start = 1'b0;
        nvec++;
        if (done_m !== 1'b1 || busy_m !== 1'b0 || tx_m !== 1'b1) begin
            nerr++;
            $display("FAIL %s done_cycle %0d: tx=%b busy=%b done=%b, required tx=1 busy=0 done=1",
                     name, n_bits * CPB + 1, tx_m, busy_m, done_m);
        end
    endtask

    task automatic test_reset();
        sel      = 0;
        reset    = 1'b1;
        en       = 1'b0;
        tx_start = 1'b0;
        data_in  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset_hold");
        end
        reset    = 1'b0;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 3; d++) begin
                sel = d;
                #0;
                check_idle("start_while_disabled");
            end
            sel = 0;
            step();
        end
    endtask

    task automatic test_basic_frame();
        quiesce();
        sel = 0;
        accept(8'hA5, 0, 1);
        check_frame(0, 1, 0, 8'h00, 0, 0, "frame_a5");
        step();
        check_idle("done_single_pulse");
    endtask

    task automatic test_parity();
        quiesce();
        sel = 1;
        accept(8'h07, 1, 1);
        check_frame(1, 1, 0, 8'h00, 0, 0, "parity_07");
        step();
        check_idle("parity_07_after");
        accept(8'h03, 1, 1);
        check_frame(1, 1, 0, 8'h00, 0, 0, "parity_03");
    endtask

    task automatic test_back_to_back();
        quiesce();
        sel = 0;
        accept(8'h3C, 0, 1);
        check_frame(0, 1, 15, 8'hFF, 0, 0, "busy_ignore_3c");
        // Request in the done cycle: next start bit must follow immediately
        accept(8'h55, 0, 1);
        check_frame(0, 1, 0, 8'h00, 0, 0, "back_to_back_55");
    endtask

    task automatic test_abort();
        quiesce();
        sel = 0;
        accept(8'hC3, 0, 1);
        // DATA bit 3 occupies cycles 17..20
        check_frame(0, 1, 0, 8'h00, 18, 0, "abort_c3");
        accept(8'h5A, 0, 1);
        check_frame(0, 1, 0, 8'h00, 0, 0, "after_abort_5a");
    endtask

    task automatic test_reset_in_stop();
        quiesce();
        sel = 2;
        accept(8'h96, 0, 2);
        // STOP spans cycles 37..44
        check_frame(0, 2, 0, 8'h00, 0, 40, "reset_in_stop");
        accept(8'h81, 0, 2);
        check_frame(0, 2, 0, 8'h00, 0, 0, "two_stop_81");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_abort();
        test_reset_in_stop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
